// File: rtl/vec_decode_pkg.sv
// -----------------------------------------------------------------------------
// vec_decode_pkg
// Shared types and the opcode decoder for the vector decode stage.
//   opcode_e   : 4-bit opcode encoding (OP_NOP..OP_BEQ)
//   ALU_*      : 3-bit ALU operation codes driven to execute
//   ctrl_t     : decoded execute-stage control bundle
//   decode_op  : opcode -> ctrl_t; an invalid slot decodes as a NOP
// -----------------------------------------------------------------------------
package vec_decode_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_XOR   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9,
        OP_BEQ   = 4'hA
    } opcode_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       result_src;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic valid, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        if (valid) begin
            case (opcode_e'(op))
                OP_NOP:   ;
                OP_ADD:   begin c.reg_write = 1'b1; c.alu_ctrl = ALU_ADD; end
                OP_SUB:   begin c.reg_write = 1'b1; c.alu_ctrl = ALU_SUB; end
                OP_XOR:   begin c.reg_write = 1'b1; c.alu_ctrl = ALU_XOR; end
                OP_AND:   begin c.reg_write = 1'b1; c.alu_ctrl = ALU_AND; end
                OP_OR:    begin c.reg_write = 1'b1; c.alu_ctrl = ALU_OR;  end
                OP_SHL:   begin c.reg_write = 1'b1; c.alu_ctrl = ALU_SHL; end
                OP_SHR:   begin c.reg_write = 1'b1; c.alu_ctrl = ALU_SHR; end
                OP_LOAD:  begin c.reg_write = 1'b1; c.result_src = 1'b1; c.alu_ctrl = ALU_ADD; end
                OP_STORE: begin c.mem_write = 1'b1; c.alu_ctrl = ALU_ADD; end
                // BEQ compares by subtraction in execute
                OP_BEQ:   begin c.branch = 1'b1; c.alu_ctrl = ALU_SUB; end
                default:  c.illegal = 1'b1;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/vec_regfile.sv
// -----------------------------------------------------------------------------
// vec_regfile
// One lane of the architectural register file: NREGS x DATA_W, one write
// port, two combinational read ports with write-through bypass. r0 is
// hardwired to zero (writes to it are dropped, reads return 0).
//   clk, rst        : clock, synchronous active-high reset (clears all regs)
//   we, wAddr, wData: writeback port
//   rAddr1, rAddr2  : read addresses
//   rData1, rData2  : read data (bypassed from the write port on a match)
// -----------------------------------------------------------------------------
module vec_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RW-1:0]     wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic [RW-1:0]     rAddr1,
    input  logic [RW-1:0]     rAddr2,
    output logic [DATA_W-1:0] rData1,
    output logic [DATA_W-1:0] rData2
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wrEn;

    assign wrEn = we && (wAddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[wAddr] <= wData;
        end
    end

    // Bypass makes a same-cycle writeback visible to the decoding instruction,
    // so the D/E register never captures a stale operand. wrEn already
    // excludes r0, so r0 can never bypass.
    always_comb begin
        rData1 = '0;
        if (rAddr1 != '0) begin
            rData1 = (wrEn && (wAddr == rAddr1)) ? wData : regs[rAddr1];
        end
    end

    always_comb begin
        rData2 = '0;
        if (rAddr2 != '0) begin
            rData2 = (wrEn && (wAddr == rAddr2)) ? wData : regs[rAddr2];
        end
    end

endmodule

// File: rtl/vec_decode_stage.sv
// -----------------------------------------------------------------------------
// vec_decode_stage
// Vector decode stage: per-lane register files, instruction decode and the
// decode/execute pipeline register.
//   clk, rst            : clock, synchronous active-high reset
//   valid_d, inst_d     : fetched instruction ([15:12] op, [11:8] rd,
//                         [7:4] ra1, [3:0] ra2)
//   stall_d, flush_d    : hold / bubble the D/E register (flush wins)
//   wb_we/wb_rd/wb_data : per-lane writeback (lane l in slice l)
//   valid_e, rd_e       : D/E valid and destination
//   rs1_e, rs2_e        : per-lane operands (lane l in slice l)
//   reg_write_e, mem_write_e, branch_e, result_src_e, alu_ctrl_e, illegal_e
//                       : registered execute control
// -----------------------------------------------------------------------------
module vec_decode_stage
    import vec_decode_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_d,
    input  logic [15:0]             inst_d,
    input  logic                    stall_d,
    input  logic                    flush_d,
    input  logic [LANES-1:0]        wb_we,
    input  logic [LANES*RW-1:0]     wb_rd,
    input  logic [LANES*DATA_W-1:0] wb_data,
    output logic                    valid_e,
    output logic [RW-1:0]           rd_e,
    output logic [LANES*DATA_W-1:0] rs1_e,
    output logic [LANES*DATA_W-1:0] rs2_e,
    output logic                    reg_write_e,
    output logic                    mem_write_e,
    output logic                    branch_e,
    output logic                    result_src_e,
    output logic [2:0]              alu_ctrl_e,
    output logic                    illegal_e
);

    logic [RW-1:0]           rdD;
    logic [RW-1:0]           ra1D;
    logic [RW-1:0]           ra2D;
    logic [LANES*DATA_W-1:0] rs1Next;
    logic [LANES*DATA_W-1:0] rs2Next;
    ctrl_t                   ctrlNext;
    ctrl_t                   ctrlE;

    assign rdD  = inst_d[8 +: RW];
    assign ra1D = inst_d[4 +: RW];
    assign ra2D = inst_d[0 +: RW];

    assign ctrlNext = decode_op(valid_d, inst_d[15:12]);

    // Writes proceed independently of stall/flush; only rst clears the banks.
    for (genvar l = 0; l < LANES; l++) begin : gLane
        vec_regfile #(
            .DATA_W (DATA_W),
            .NREGS  (NREGS),
            .RW     (RW)
        ) uRegfile (
            .clk    (clk),
            .rst    (rst),
            .we     (wb_we[l]),
            .wAddr  (wb_rd[l*RW +: RW]),
            .wData  (wb_data[l*DATA_W +: DATA_W]),
            .rAddr1 (ra1D),
            .rAddr2 (ra2D),
            .rData1 (rs1Next[l*DATA_W +: DATA_W]),
            .rData2 (rs2Next[l*DATA_W +: DATA_W])
        );
    end

    // Reset and flush both load an all-zero bubble; stall holds every field.
    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            valid_e <= 1'b0;
            rd_e    <= '0;
            rs1_e   <= '0;
            rs2_e   <= '0;
            ctrlE   <= '0;
        end else if (!stall_d) begin
            valid_e <= valid_d;
            rd_e    <= rdD;
            rs1_e   <= rs1Next;
            rs2_e   <= rs2Next;
            ctrlE   <= ctrlNext;
        end
    end

    assign reg_write_e  = ctrlE.reg_write;
    assign mem_write_e  = ctrlE.mem_write;
    assign branch_e     = ctrlE.branch;
    assign result_src_e = ctrlE.result_src;
    assign alu_ctrl_e   = ctrlE.alu_ctrl;
    assign illegal_e    = ctrlE.illegal;

endmodule

// File: tb/tb_vec_decode_stage.sv
module tb_vec_decode_stage;

    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int RW     = 4;

    logic                    clk;
    logic                    rst;
    logic                    valid_d;
    logic [15:0]             inst_d;
    logic                    stall_d;
    logic                    flush_d;
    logic [LANES-1:0]        wb_we;
    logic [LANES*RW-1:0]     wb_rd;
    logic [LANES*DATA_W-1:0] wb_data;
    logic                    valid_e;
    logic [RW-1:0]           rd_e;
    logic [LANES*DATA_W-1:0] rs1_e;
    logic [LANES*DATA_W-1:0] rs2_e;
    logic                    reg_write_e;
    logic                    mem_write_e;
    logic                    branch_e;
    logic                    result_src_e;
    logic [2:0]              alu_ctrl_e;
    logic                    illegal_e;

    int checks = 0;
    int errors = 0;

    vec_decode_stage #(.LANES(LANES), .DATA_W(DATA_W), .NREGS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_d      (valid_d),
        .inst_d       (inst_d),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .valid_e      (valid_e),
        .rd_e         (rd_e),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .reg_write_e  (reg_write_e),
        .mem_write_e  (mem_write_e),
        .branch_e     (branch_e),
        .result_src_e (result_src_e),
        .alu_ctrl_e   (alu_ctrl_e),
        .illegal_e    (illegal_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Same writeback address/data in every lane.
    task automatic setWb(input logic [3:0] we, input logic [3:0] rd, input logic [15:0] d);
        wb_we   = we;
        wb_rd   = {4{rd}};
        wb_data = {4{d}};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_d = 1'b1;
        inst_d = 16'h1234;
        step();
        step();
        checks++;
        if ({valid_e, rd_e, rs1_e, rs2_e, reg_write_e, mem_write_e, branch_e,
             result_src_e, alu_ctrl_e, illegal_e} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b rd=%h rs1=%h rs2=%h ctrl=%b%b%b%b%b%b required all 0",
                     valid_e, rd_e, rs1_e, rs2_e, reg_write_e, mem_write_e, branch_e,
                     result_src_e, alu_ctrl_e, illegal_e);
        end
        rst = 1'b0;
        for (int i = 1; i < 16; i++) begin
            inst_d = {4'h1, 4'h0, i[3:0], i[3:0]};
            step();
            checks++;
            if (rs1_e !== 64'h0 || rs2_e !== 64'h0) begin
                errors++;
                $display("FAIL reset_reg_r%0d: rs1=%h rs2=%h required 0", i, rs1_e, rs2_e);
            end
        end
    endtask

    task automatic test_write_read();
        valid_d = 1'b0;
        setWb(4'hF, 4'h1, 16'h1234);
        step();
        setWb(4'h0, 4'h0, 16'h0);
        valid_d = 1'b1;
        inst_d = 16'h1012;
        step();
        checks++;
        if (rs1_e !== {4{16'h1234}} || rs2_e !== 64'h0) begin
            errors++;
            $display("FAIL write_read_ops: rs1=%h rs2=%h required 1234x4 / 0", rs1_e, rs2_e);
        end
        checks++;
        if ({valid_e, reg_write_e, alu_ctrl_e, rd_e} !== {1'b1, 1'b1, 3'b000, 4'h0}) begin
            errors++;
            $display("FAIL write_read_ctrl: valid=%b regW=%b alu=%b rd=%h required 1 1 000 0",
                     valid_e, reg_write_e, alu_ctrl_e, rd_e);
        end
        valid_d = 1'b0;
        setWb(4'hF, 4'h1, 16'h5678);
        step();
        setWb(4'h0, 4'h0, 16'h0);
        valid_d = 1'b1;
        inst_d = 16'h1012;
        step();
        checks++;
        if (rs1_e !== {4{16'h5678}}) begin
            errors++;
            $display("FAIL write_read_overwrite: rs1=%h required 5678x4", rs1_e);
        end
    endtask

    task automatic test_bypass();
        valid_d = 1'b0;
        setWb(4'hF, 4'h2, 16'h1111);
        step();
        // lane 2 only, same cycle as the decode read of r2 on both sources
        wb_we   = 4'b0100;
        wb_rd   = {4{4'h2}};
        wb_data = {16'h0, 16'h9abc, 16'h0, 16'h0};
        valid_d = 1'b1;
        inst_d  = 16'h2322;
        step();
        checks++;
        if (rs1_e !== {16'h1111, 16'h9abc, 16'h1111, 16'h1111} ||
            rs2_e !== {16'h1111, 16'h9abc, 16'h1111, 16'h1111}) begin
            errors++;
            $display("FAIL bypass_same_cycle: rs1=%h rs2=%h required 1111_9abc_1111_1111", rs1_e, rs2_e);
        end
        checks++;
        if (alu_ctrl_e !== 3'b001 || rd_e !== 4'h3) begin
            errors++;
            $display("FAIL bypass_ctrl: alu=%b rd=%h required 001 3", alu_ctrl_e, rd_e);
        end
        setWb(4'h0, 4'h0, 16'h0);
        step();
        checks++;
        if (rs1_e !== {16'h1111, 16'h9abc, 16'h1111, 16'h1111}) begin
            errors++;
            $display("FAIL bypass_stored: rs1=%h required 1111_9abc_1111_1111", rs1_e);
        end
        // independent per source: only ra2 (r1) bypasses, in lane 0 only
        wb_we   = 4'b0001;
        wb_rd   = {4{4'h1}};
        wb_data = {48'h0, 16'h4444};
        inst_d  = 16'h1021;
        step();
        checks++;
        if (rs1_e !== {16'h1111, 16'h9abc, 16'h1111, 16'h1111} ||
            rs2_e !== {16'h5678, 16'h5678, 16'h5678, 16'h4444}) begin
            errors++;
            $display("FAIL bypass_per_source: rs1=%h rs2=%h required 1111_9abc_1111_1111 / 5678_5678_5678_4444",
                     rs1_e, rs2_e);
        end
        // r0 writes dropped, never bypassed
        setWb(4'hF, 4'h0, 16'hffff);
        inst_d = 16'h1000;
        step();
        checks++;
        if (rs1_e !== 64'h0 || rs2_e !== 64'h0) begin
            errors++;
            $display("FAIL r0_bypass: rs1=%h rs2=%h required 0", rs1_e, rs2_e);
        end
        setWb(4'h0, 4'h0, 16'h0);
        step();
        checks++;
        if (rs1_e !== 64'h0 || rs2_e !== 64'h0) begin
            errors++;
            $display("FAIL r0_read: rs1=%h rs2=%h required 0", rs1_e, rs2_e);
        end
    endtask

    task automatic test_stall_flush();
        logic [15:0] stallInst [3];
        stallInst[0] = 16'h4000;
        stallInst[1] = 16'h9123;
        stallInst[2] = 16'hA345;
        valid_d = 1'b1;
        inst_d  = 16'h3512;
        step();
        stall_d = 1'b1;
        for (int c = 0; c < 3; c++) begin
            inst_d = stallInst[c];
            // a writeback to the held operand must not disturb the held value
            if (c == 1) setWb(4'hF, 4'h1, 16'h7777);
            else        setWb(4'h0, 4'h0, 16'h0);
            step();
            checks++;
            if (valid_e !== 1'b1 || rd_e !== 4'h5 || alu_ctrl_e !== 3'b010 || reg_write_e !== 1'b1 ||
                mem_write_e !== 1'b0 || branch_e !== 1'b0 ||
                rs1_e !== {16'h5678, 16'h5678, 16'h5678, 16'h4444} ||
                rs2_e !== {16'h1111, 16'h9abc, 16'h1111, 16'h1111}) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid=%b rd=%h alu=%b rs1=%h rs2=%h required held XOR rd5",
                         c, valid_e, rd_e, alu_ctrl_e, rs1_e, rs2_e);
            end
        end
        stall_d = 1'b0;
        inst_d  = 16'h3512;
        step();
        checks++;
        if (rs1_e !== {4{16'h7777}} || alu_ctrl_e !== 3'b010) begin
            errors++;
            $display("FAIL stall_reread: rs1=%h alu=%b required 7777x4 010", rs1_e, alu_ctrl_e);
        end
        inst_d  = 16'h1123;
        stall_d = 1'b1;
        flush_d = 1'b1;
        step();
        checks++;
        if ({valid_e, rd_e, rs1_e, rs2_e, reg_write_e, mem_write_e, branch_e,
             result_src_e, alu_ctrl_e, illegal_e} !== '0) begin
            errors++;
            $display("FAIL flush_over_stall: valid=%b rd=%h rs1=%h regW=%b alu=%b required all 0",
                     valid_e, rd_e, rs1_e, reg_write_e, alu_ctrl_e);
        end
        stall_d = 1'b0;
        flush_d = 1'b0;
    endtask

    task automatic test_decode_sweep();
        // {alu[2:0], regW, memW, branch, resSrc, illegal}
        logic [7:0] table_ [16];
        logic [7:0] got;
        table_[0]  = 8'b000_00000;
        table_[1]  = 8'b000_10000;
        table_[2]  = 8'b001_10000;
        table_[3]  = 8'b010_10000;
        table_[4]  = 8'b011_10000;
        table_[5]  = 8'b100_10000;
        table_[6]  = 8'b101_10000;
        table_[7]  = 8'b110_10000;
        table_[8]  = 8'b000_10010;
        table_[9]  = 8'b000_01000;
        table_[10] = 8'b001_00100;
        for (int i = 11; i < 16; i++) table_[i] = 8'b000_00001;
        valid_d = 1'b1;
        for (int op = 0; op < 16; op++) begin
            inst_d = {op[3:0], 12'h000};
            step();
            got = {alu_ctrl_e, reg_write_e, mem_write_e, branch_e, result_src_e, illegal_e};
            checks++;
            if (got !== table_[op] || valid_e !== 1'b1) begin
                errors++;
                $display("FAIL decode_op_%h: ctrl=%b valid=%b required %b 1", op[3:0], got, valid_e, table_[op]);
            end
        end
        valid_d = 1'b0;
        inst_d  = 16'hB000;
        step();
        got = {alu_ctrl_e, reg_write_e, mem_write_e, branch_e, result_src_e, illegal_e};
        checks++;
        if (got !== 8'h00 || valid_e !== 1'b0) begin
            errors++;
            $display("FAIL decode_invalid: ctrl=%b valid=%b required 0 0", got, valid_e);
        end
    endtask

    task automatic test_reset_midstream();
        valid_d = 1'b1;
        inst_d  = 16'h2132;
        setWb(4'hF, 4'h3, 16'h2222);
        rst = 1'b1;
        step();
        rst = 1'b0;
        setWb(4'h0, 4'h0, 16'h0);
        checks++;
        if ({valid_e, rd_e, rs1_e, rs2_e, reg_write_e, mem_write_e, branch_e,
             result_src_e, alu_ctrl_e, illegal_e} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b rd=%h rs1=%h rs2=%h alu=%b required all 0",
                     valid_e, rd_e, rs1_e, rs2_e, alu_ctrl_e);
        end
        inst_d = 16'h1031;
        step();
        checks++;
        if (rs1_e !== 64'h0 || rs2_e !== 64'h0) begin
            errors++;
            $display("FAIL midreset_regs: rs1=%h rs2=%h required 0 (r3, r1 cleared)", rs1_e, rs2_e);
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_d = 1'b0;
        inst_d = 16'h0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        wb_we = '0;
        wb_rd = '0;
        wb_data = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_stall_flush();
        test_decode_sweep();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
